// File: rtl/sargantana_icache_pkg.sv
// Shared types and sizing for the instruction-cache lookup controller.
package sargantana_icache_pkg;

   localparam int unsigned ICACHE_N_WAY      = 4;
   localparam int unsigned ICACHE_DEPTH      = 64;
   localparam int unsigned ICACHE_IDX_WIDTH  = $clog2(ICACHE_DEPTH);
   localparam int unsigned ICACHE_WAY_IDX_W  = $clog2(ICACHE_N_WAY);

   typedef logic [ICACHE_IDX_WIDTH-1:0] idx_t;
   typedef logic [ICACHE_N_WAY-1:0]     way_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS_REQ,
      S_MISS_WAIT,
      S_REFILL,
      S_REPLAY,
      S_FLUSH
   } icache_state_e;

endpackage

// File: rtl/sargantana_icache_ctrl_if.sv
// Fetch, array and refill signals seen by the icache controller.
interface sargantana_icache_ctrl_if;
   import sargantana_icache_pkg::*;

   logic lookup_req_i;
   idx_t req_idx_i;
   logic lookup_ready_o;
   logic paddr_valid_i;
   logic kill_i;
   logic flush_i;
   way_t cline_hit_i;
   way_t way_valid_bits_i;
   logic cmp_enable_o;
   logic resp_valid_o;
   logic ifill_req_valid_o;
   logic ifill_req_ready_i;
   logic ifill_resp_valid_i;
   idx_t addr_idx_o;
   way_t fill_way_o;
   logic tag_we_o;
   logic data_we_o;
   logic valid_we_o;
   logic valid_clr_o;
   logic busy_o;

   // Environment side: front-end, checker and lower level
   modport master (
      output lookup_req_i, req_idx_i, paddr_valid_i, kill_i, flush_i,
             cline_hit_i, way_valid_bits_i, ifill_req_ready_i, ifill_resp_valid_i,
      input  lookup_ready_o, cmp_enable_o, resp_valid_o, ifill_req_valid_o,
             addr_idx_o, fill_way_o, tag_we_o, data_we_o, valid_we_o,
             valid_clr_o, busy_o
   );

   modport slave (
      input  lookup_req_i, req_idx_i, paddr_valid_i, kill_i, flush_i,
             cline_hit_i, way_valid_bits_i, ifill_req_ready_i, ifill_resp_valid_i,
      output lookup_ready_o, cmp_enable_o, resp_valid_o, ifill_req_valid_o,
             addr_idx_o, fill_way_o, tag_we_o, data_we_o, valid_we_o,
             valid_clr_o, busy_o
   );

endinterface

// File: rtl/sargantana_icache_replace.sv
// Victim way choice: lowest invalid way, else a round-robin pointer that
// only advances when a refill actually consumed it.
module sargantana_icache_replace
   import sargantana_icache_pkg::*;
(
   input  logic clk_i,
   input  logic rstn_i,
   input  way_t way_valid_i,
   input  logic latch_i,
   input  logic advance_i,
   output way_t victim_o
);

   logic [ICACHE_WAY_IDX_W-1:0] rr_q, rr_d;
   way_t victim_q, victim_d;
   logic used_rr_q, used_rr_d;
   way_t first_inv;

   always_comb begin
      first_inv = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (!way_valid_i[i]) begin
            first_inv    = '0;
            first_inv[i] = 1'b1;
         end
      end

      rr_d      = rr_q;
      victim_d  = victim_q;
      used_rr_d = used_rr_q;

      if (latch_i) begin
         if (&way_valid_i) begin
            victim_d  = way_t'(1) << rr_q;
            used_rr_d = 1'b1;
         end else begin
            victim_d  = first_inv;
            used_rr_d = 1'b0;
         end
      end

      if (advance_i && used_rr_q) begin
         rr_d      = (rr_q == ICACHE_WAY_IDX_W'(ICACHE_N_WAY - 1)) ? '0
                                                                  : rr_q + ICACHE_WAY_IDX_W'(1);
         used_rr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rr_q      <= '0;
         victim_q  <= '0;
         used_rr_q <= 1'b0;
      end else begin
         rr_q      <= rr_d;
         victim_q  <= victim_d;
         used_rr_q <= used_rr_d;
      end
   end

   assign victim_o = victim_q;

endmodule

// File: rtl/sargantana_icache_ctrl.sv
// Icache sequencing: lookup, miss/refill handshake, replay and set-by-set
// valid flush. Array/handshake strobes decode from the current state.
module sargantana_icache_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter bit FLUSH_ON_RESET = 1'b1
) (
   input logic                     clk_i,
   input logic                     rstn_i,
   sargantana_icache_ctrl_if.slave bus
);

   icache_state_e state_q, state_d;
   idx_t          idx_q, idx_d;
   idx_t          flush_cnt_q, flush_cnt_d;
   logic          kill_pending_q, kill_pending_d;
   logic          flush_pending_q, flush_pending_d;
   logic          victim_latch;
   way_t          victim;

   sargantana_icache_replace u_replace (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .way_valid_i (bus.way_valid_bits_i),
      .latch_i     (victim_latch),
      .advance_i   (state_q == S_REFILL),
      .victim_o    (victim)
   );

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      flush_cnt_d     = flush_cnt_q;
      kill_pending_d  = kill_pending_q;
      flush_pending_d = flush_pending_q |
                        (bus.flush_i && state_q != S_IDLE && state_q != S_FLUSH);

      bus.lookup_ready_o    = 1'b0;
      bus.cmp_enable_o      = 1'b0;
      bus.resp_valid_o      = 1'b0;
      bus.ifill_req_valid_o = 1'b0;
      bus.tag_we_o          = 1'b0;
      bus.data_we_o         = 1'b0;
      bus.valid_we_o        = 1'b0;
      bus.valid_clr_o       = 1'b0;
      bus.addr_idx_o        = idx_q;
      bus.fill_way_o        = '0;
      victim_latch          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Flush wins over a same-cycle request, so the request is not acknowledged
            bus.lookup_ready_o = !flush_pending_q && !bus.flush_i;
            if (bus.flush_i || flush_pending_q) begin
               state_d     = S_FLUSH;
               flush_cnt_d = '0;
            end else if (bus.lookup_req_i) begin
               idx_d   = bus.req_idx_i;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            bus.cmp_enable_o = bus.paddr_valid_i;
            if (bus.kill_i) begin
               state_d = S_IDLE;
            end else if (bus.paddr_valid_i) begin
               if (|bus.cline_hit_i) begin
                  bus.resp_valid_o = 1'b1;
                  if (bus.lookup_req_i && !flush_pending_q && !bus.flush_i) begin
                     bus.lookup_ready_o = 1'b1;
                     idx_d              = bus.req_idx_i;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  victim_latch = 1'b1;
                  state_d      = S_MISS_REQ;
               end
            end
         end
         S_MISS_REQ: begin
            bus.ifill_req_valid_o = 1'b1;
            // Once handshaken the refill is owed to us; a kill only marks it
            if (bus.ifill_req_ready_i) begin
               state_d        = S_MISS_WAIT;
               kill_pending_d = kill_pending_q | bus.kill_i;
            end else if (bus.kill_i) begin
               state_d = S_IDLE;
            end
         end
         S_MISS_WAIT: begin
            if (bus.kill_i) kill_pending_d = 1'b1;
            if (bus.ifill_resp_valid_i) state_d = S_REFILL;
         end
         S_REFILL: begin
            bus.tag_we_o   = 1'b1;
            bus.data_we_o  = 1'b1;
            bus.valid_we_o = 1'b1;
            bus.fill_way_o = victim;
            if (kill_pending_q || bus.kill_i || flush_pending_d) begin
               state_d        = S_IDLE;
               kill_pending_d = 1'b0;
            end else begin
               state_d = S_REPLAY;
            end
         end
         S_REPLAY: begin
            state_d = bus.kill_i ? S_IDLE : S_LOOKUP;
         end
         S_FLUSH: begin
            bus.valid_clr_o = 1'b1;
            bus.addr_idx_o  = flush_cnt_q;
            if (bus.flush_i) begin
               flush_cnt_d = '0;
            end else if (flush_cnt_q == idx_t'(ICACHE_DEPTH - 1)) begin
               flush_cnt_d     = '0;
               flush_pending_d = 1'b0;
               state_d         = S_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + idx_t'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q         <= FLUSH_ON_RESET ? S_FLUSH : S_IDLE;
         idx_q           <= '0;
         flush_cnt_q     <= '0;
         kill_pending_q  <= 1'b0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         flush_cnt_q     <= flush_cnt_d;
         kill_pending_q  <= kill_pending_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   assign bus.busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Directed bench for sargantana_icache_ctrl with a scoreboard of array/response events.
module tb_sargantana_icache_ctrl;
   import sargantana_icache_pkg::*;

   logic clk_i = 1'b0;
   logic rstn_i;
   always #5 clk_i = ~clk_i;

   sargantana_icache_ctrl_if bus();

   sargantana_icache_ctrl #(.FLUSH_ON_RESET(1'b1)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .bus    (bus)
   );

   localparam logic [1:0] K_RESP = 2'd0, K_FILL = 2'd1, K_CLR = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [5:0] idx;
      logic [3:0] way;
      logic [2:0] we;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [5:0] idx, input logic [3:0] way);
      ev_t e;
      e.kind = k;
      e.idx  = idx;
      e.way  = way;
      e.we   = (k == K_FILL) ? 3'b111 : 3'b000;
      exp_q.push_back(e);
   endtask

   // Monitor: every observable array/response event must match the next expectation
   always @(negedge clk_i) begin
      if (rstn_i) begin
         ev_t a;
         logic seen;
         seen = 1'b0;
         a    = '0;
         if (bus.resp_valid_o) begin
            a.kind = K_RESP; a.idx = bus.addr_idx_o; seen = 1'b1;
         end else if (bus.tag_we_o || bus.data_we_o || bus.valid_we_o) begin
            a.kind = K_FILL; a.idx = bus.addr_idx_o; a.way = bus.fill_way_o;
            a.we   = {bus.tag_we_o, bus.data_we_o, bus.valid_we_o};
            seen   = 1'b1;
         end else if (bus.valid_clr_o) begin
            a.kind = K_CLR; a.idx = bus.addr_idx_o; seen = 1'b1;
         end
         if (seen) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", 32'(a), 32'h7fff);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("event", 32'(a), 32'(e));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic accept(input logic [5:0] idx);
      step();
      bus.lookup_req_i = 1'b1;
      bus.req_idx_i    = idx;
      @(negedge clk_i) chk("accept_ready", 32'(bus.lookup_ready_o), 32'd1);
      step();
      bus.lookup_req_i = 1'b0;
   endtask

   task automatic miss(input logic [5:0] idx, input logic [3:0] wvb, input int nready,
                       input int nresp, input logic [3:0] exp_way,
                       input bit do_kill, input bit do_flush);
      accept(idx);
      bus.paddr_valid_i    = 1'b1;
      bus.cline_hit_i      = 4'b0000;
      bus.way_valid_bits_i = wvb;
      @(negedge clk_i);
      chk("miss_cmp", 32'(bus.cmp_enable_o), 32'd1);
      chk("miss_no_resp", 32'(bus.resp_valid_o), 32'd0);
      step();
      bus.paddr_valid_i = 1'b0;
      for (int i = 0; i < nready; i++) begin
         if (i == 0) bus.flush_i = do_flush;
         @(negedge clk_i) chk("req_hold", 32'(bus.ifill_req_valid_o), 32'd1);
         step();
         bus.flush_i = 1'b0;
      end
      bus.ifill_req_ready_i = 1'b1;
      @(negedge clk_i) chk("req_handshake", 32'(bus.ifill_req_valid_o), 32'd1);
      step();
      bus.ifill_req_ready_i = 1'b0;
      for (int i = 0; i < nresp; i++) begin
         if (i == 0) bus.kill_i = do_kill;
         if (i == 0) @(negedge clk_i) chk("wait_req_low", 32'(bus.ifill_req_valid_o), 32'd0);
         step();
         bus.kill_i = 1'b0;
      end
      push(K_FILL, idx, exp_way);
      bus.ifill_resp_valid_i = 1'b1;
      step();
      bus.ifill_resp_valid_i = 1'b0;
      @(negedge clk_i);
      step();
      if (do_kill || do_flush) begin
         if (do_flush) begin
            bus.lookup_req_i = 1'b1;
            bus.req_idx_i    = 6'd3;
            for (int i = 0; i < ICACHE_DEPTH; i++) push(K_CLR, 6'(i), 4'b0000);
         end
         @(negedge clk_i) chk("abort_idle", 32'(bus.busy_o), 32'd0);
         if (do_flush) chk("pending_blocks_req", 32'(bus.lookup_ready_o), 32'd0);
      end else begin
         @(negedge clk_i) chk("replay_busy", 32'(bus.busy_o), 32'd1);
         step();
         bus.paddr_valid_i = 1'b1;
         bus.cline_hit_i   = exp_way;
         push(K_RESP, idx, 4'b0000);
         @(negedge clk_i) chk("replay_hit", 32'(bus.resp_valid_o), 32'd1);
         step();
         bus.paddr_valid_i = 1'b0;
         bus.cline_hit_i   = 4'b0000;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int bad;
      rstn_i                 = 1'b0;
      bus.lookup_req_i       = 1'b0;
      bus.req_idx_i          = '0;
      bus.paddr_valid_i      = 1'b0;
      bus.kill_i             = 1'b0;
      bus.flush_i            = 1'b0;
      bus.cline_hit_i        = '0;
      bus.way_valid_bits_i   = '0;
      bus.ifill_req_ready_i  = 1'b0;
      bus.ifill_resp_valid_i = 1'b0;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_busy", 32'(bus.busy_o), 32'd1);
      chk("rst_ready", 32'(bus.lookup_ready_o), 32'd0);
      chk("rst_ifill", 32'(bus.ifill_req_valid_o), 32'd0);
      chk("rst_resp", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_idx", 32'(bus.addr_idx_o), 32'd0);
      for (int i = 0; i < ICACHE_DEPTH; i++) push(K_CLR, 6'(i), 4'b0000);
      @(posedge clk_i);
      #1 rstn_i = 1'b1;

      cyc = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_i);
         if (!bus.busy_o) break;
         cyc++;
      end
      chk("reset_flush_len", 32'(cyc), 32'd64);
      chk("idle_ready", 32'(bus.lookup_ready_o), 32'd1);

      // Single hit
      accept(6'd5);
      bus.paddr_valid_i = 1'b1;
      bus.cline_hit_i   = 4'b0100;
      push(K_RESP, 6'd5, 4'b0000);
      @(negedge clk_i);
      chk("hit_latency", 32'(bus.resp_valid_o), 32'd1);
      chk("hit_no_ifill", 32'(bus.ifill_req_valid_o), 32'd0);
      step();
      bus.paddr_valid_i = 1'b0;
      bus.cline_hit_i   = 4'b0000;
      @(negedge clk_i) chk("hit_back_idle", 32'(bus.busy_o), 32'd0);

      // Back-to-back hits
      accept(6'd7);
      bus.paddr_valid_i = 1'b1;
      bus.cline_hit_i   = 4'b0001;
      bus.lookup_req_i  = 1'b1;
      bus.req_idx_i     = 6'd8;
      push(K_RESP, 6'd7, 4'b0000);
      @(negedge clk_i) chk("b2b_ready", 32'(bus.lookup_ready_o), 32'd1);
      step();
      bus.lookup_req_i = 1'b0;
      push(K_RESP, 6'd8, 4'b0000);
      @(negedge clk_i) chk("b2b_second", 32'(bus.resp_valid_o), 32'd1);
      step();
      bus.paddr_valid_i = 1'b0;
      bus.cline_hit_i   = 4'b0000;

      // Miss into the only invalid way, slow lower level
      miss(6'd5, 4'b0111, 3, 10, 4'b1000, 1'b0, 1'b0);

      // Full set: round-robin rotation
      miss(6'd10, 4'b1111, 0, 2, 4'b0001, 1'b0, 1'b0);
      miss(6'd11, 4'b1111, 1, 2, 4'b0010, 1'b0, 1'b0);
      miss(6'd12, 4'b1111, 0, 3, 4'b0100, 1'b0, 1'b0);
      miss(6'd13, 4'b1111, 2, 1, 4'b1000, 1'b0, 1'b0);
      miss(6'd14, 4'b1111, 0, 2, 4'b0001, 1'b0, 1'b0);

      // Kill while waiting for the refill
      miss(6'd20, 4'b1111, 1, 4, 4'b0010, 1'b1, 1'b0);

      // Flush arriving during the refill request
      miss(6'd9, 4'b0000, 3, 3, 4'b0001, 1'b0, 1'b1);
      cyc = 0;
      bad = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_i);
         if (!bus.busy_o) break;
         cyc++;
         if (bus.lookup_ready_o) bad++;
      end
      chk("flush_len", 32'(cyc), 32'd64);
      chk("flush_no_accept", 32'(bad), 32'd0);
      chk("post_flush_ready", 32'(bus.lookup_ready_o), 32'd1);
      bus.lookup_req_i = 1'b0;

      repeat (3) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
